// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a shared JK storage bank.
// Each grant drives one load strobe, waits a settle cycle, then checks the readback against a shadow copy.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op_flat,
  input  logic [WIDTH*NREQ-1:0]   mask_flat,
  input  logic [WIDTH-1:0]        q_in,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out,
  output logic                    load,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        rdata,
  output logic                    busy,
  output logic                    err
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] DRIVE  = 2'b01;
  localparam logic [1:0] SETTLE = 2'b10;
  localparam logic [1:0] ACK    = 2'b11;

  logic [1:0]       state;
  logic [GW-1:0]    ptr;
  logic [GW-1:0]    g;
  logic [1:0]       op_l;
  logic [WIDTH-1:0] mask_l;
  logic [WIDTH-1:0] shadow;

  logic [GW-1:0]    grant_idx;
  logic [1:0]       grant_op;
  logic [WIDTH-1:0] grant_mask;

  // Expected bank contents after a JK load: j,k = 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] cur,
                                                input logic [1:0]       op,
                                                input logic [WIDTH-1:0] mask);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int b = 0; b < WIDTH; b++) begin
      if (mask[b]) begin
        case (op)
          2'b01:   nxt[b] = 1'b0;
          2'b10:   nxt[b] = 1'b1;
          2'b11:   nxt[b] = ~cur[b];
          default: nxt[b] = cur[b];
        endcase
      end
    end
    return nxt;
  endfunction

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic found;
    found     = 1'b0;
    grant_idx = ptr;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = GW'(idx);
      end
    end
  end

  always_comb begin
    grant_op   = op_flat[2*int'(grant_idx) +: 2];
    grant_mask = mask_flat[WIDTH*int'(grant_idx) +: WIDTH];
  end

  assign busy = (state != IDLE);

  // Outputs are registered, so each strobe appears one cycle after the state that issues it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      g      <= '0;
      op_l   <= 2'b00;
      mask_l <= '0;
      shadow <= '0;
      j_out  <= '0;
      k_out  <= '0;
      load   <= 1'b0;
      ack    <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      load  <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            g      <= grant_idx;
            op_l   <= grant_op;
            mask_l <= grant_mask;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          load   <= 1'b1;
          j_out  <= mask_l & {WIDTH{op_l[1]}};
          k_out  <= mask_l & {WIDTH{op_l[0]}};
          shadow <= jk_apply(shadow, op_l, mask_l);
          state  <= SETTLE;
        end
        SETTLE: begin
          state <= ACK;
        end
        default: begin
          ack   <= NREQ'(1) << g;
          rdata <= q_in;
          if (q_in != shadow) err <= 1'b1;
          ptr   <= (g == GW'(NREQ - 1)) ? '0 : g + GW'(1);
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a behavioural JK bank (optional stuck-at-0 on bit 0 readback).
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     op_flat = '0;
  logic [WIDTH*NREQ-1:0] mask_flat = '0;
  logic [WIDTH-1:0]      q_in;
  logic [WIDTH-1:0]      j_out, k_out, rdata;
  logic                  load, busy, err;
  logic [NREQ-1:0]       ack;

  logic [WIDTH-1:0]      bank_q;
  logic                  fault = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .op_flat(op_flat), .mask_flat(mask_flat),
    .q_in(q_in), .j_out(j_out), .k_out(k_out), .load(load), .ack(ack),
    .rdata(rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bank_q <= '0;
    else if (load) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end

  assign q_in = fault ? (bank_q & 8'hFE) : bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One single-requester transaction, starting and ending on a falling edge with the DUT idle.
  task automatic txn(input string tag, input int r, input logic [1:0] op, input logic [7:0] mask,
                     input logic [7:0] ej, input logic [7:0] ek, input logic [7:0] erd,
                     input logic eerr);
    op_flat   = '0;
    mask_flat = '0;
    op_flat[2*r +: 2]   = op;
    mask_flat[8*r +: 8] = mask;
    req = 4'(1 << r);
    @(posedge clk); @(negedge clk);
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    chk({tag, ".load0"}, 32'(load), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".load1"}, 32'(load), 32'd1);
    chk({tag, ".j1"}, 32'(j_out), 32'(ej));
    chk({tag, ".k1"}, 32'(k_out), 32'(ek));
    chk({tag, ".ack1"}, 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".load2"}, 32'(load), 32'd0);
    chk({tag, ".jk2"}, 32'({j_out, k_out}), 32'd0);
    chk({tag, ".ack2"}, 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".ack3"}, 32'(ack), 32'(1 << r));
    chk({tag, ".rdata"}, 32'(rdata), 32'(erd));
    chk({tag, ".err"}, 32'(err), 32'(eerr));
    chk({tag, ".busy3"}, 32'(busy), 32'd0);
    req = '0;
  endtask

  typedef struct {
    bit         rst_before;
    bit         fault;
    int         r;
    logic [1:0] op;
    logic [7:0] mask;
    logic [7:0] exp_j;
    logic [7:0] exp_k;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order;
    int cyc;
    bit got;

    tbl[0]  = '{1'b1, 1'b0, 0, 2'b10, 8'h0F, 8'h0F, 8'h00, 8'h0F, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2, 2'b01, 8'h0F, 8'h00, 8'h0F, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1, 2'b10, 8'h3C, 8'h3C, 8'h00, 8'h3C, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h3C, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 0, 2'b01, 8'h0C, 8'h00, 8'h0C, 8'h30, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 0, 2'b10, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1, 2'b10, 8'h02, 8'h02, 8'h00, 8'h03, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 3, 2'b11, 8'h03, 8'h03, 8'h03, 8'h00, 1'b1};

    // Reset state
    #3;
    chk("rst.load", 32'(load), 32'd0);
    chk("rst.jk", 32'({j_out, k_out}), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.rdata", 32'(rdata), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) do_reset();
      fault = tbl[i].fault;
      txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].op, tbl[i].mask,
          tbl[i].exp_j, tbl[i].exp_k, tbl[i].exp_rd, tbl[i].exp_err);
    end
    fault = 1'b0;

    // Contention: all four request together and drop after their own ack
    do_reset();
    op_flat = {4{2'b10}};
    mask_flat = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b1111;
    order = 0;
    for (int c = 0; c < 24 && order < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack != '0) begin
        chk($sformatf("rr.ack%0d", order), 32'(ack), 32'(1 << order));
        chk($sformatf("rr.cyc%0d", order), 32'(c), 32'(4 * order + 3));
        chk($sformatf("rr.rdata%0d", order), 32'(rdata), 32'((1 << (order + 1)) - 1));
        req = req & ~ack;
        order++;
      end
    end
    chk("rr.count", 32'(order), 32'd4);
    req = 4'b1111;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        chk("rr.wrap", 32'(ack), 32'b0001);
      end
    end
    chk("rr.wrap_seen", 32'(got), 32'd1);
    req = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    // Reset while the bank is settling aborts the grant; it is re-run afterwards
    do_reset();
    op_flat = '0;
    mask_flat = '0;
    op_flat[5:4] = 2'b10;
    mask_flat[23:16] = 8'hFF;
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid.load_pre", 32'(load), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid.load", 32'(load), 32'd0);
    chk("mid.jk", 32'({j_out, k_out}), 32'd0);
    chk("mid.ack", 32'(ack), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.rdata", 32'(rdata), 32'd0);
    chk("mid.err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid.ack_held", 32'(ack), 32'd0);
    rst = 1'b1;
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        cyc = c;
      end
    end
    chk("mid.regrant_seen", 32'(got), 32'd1);
    chk("mid.regrant_ack", 32'(ack), 32'b0100);
    chk("mid.regrant_lat", 32'(cyc), 32'd4);
    chk("mid.regrant_rdata", 32'(rdata), 32'hFF);
    chk("mid.regrant_err", 32'(err), 32'd0);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
